cdc_reg_arbiter: RTL and testbench
==================================

# cdc_reg_arbiter

Round-robin arbiter that shares the write side of one `cdc_reg` between N requesters on the same write clock. Each requester gets a registered single-entry input slot. The arbiter moves one slot per cycle into a registered output stage and presents that stage to `cdc_reg` as `din`/`wr_en`, gated by its `full`. A requester ID travels with the word so the read domain can demultiplex. Requesters see the same full/wr_en write semantics as `cdc_reg`.

## Interface
- `N`, 4: number of requesters, 2..16.
- `WIDTH`, 128: data word width.
- `ID_WIDTH`, 2: width of `out_id`; must be ≥ clog2(N).
- `clk`  in  1: write-domain clock (the `cdc_reg` `wr_clk`).
- `rst`  in  1: reset; synchronous, active-high.
- `in_din`  in  N*WIDTH: requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- `in_wr_en`  in  N: write request per requester.
- `in_full`  out  N: slot i occupied; registered.
- `in_mask`  in  N: 1 = requester i may be granted; 0 = slot held, never granted.
- `out_dout`  out  WIDTH: to `cdc_reg.din`; registered.
- `out_id`  out  ID_WIDTH: requester index of `out_dout`; registered.
- `out_wr_en`  out  1: to `cdc_reg.wr_en`; the output-stage valid bit, registered.
- `out_full`  in  1: from `cdc_reg.full`.
- `busy`  out  1: any slot occupied OR output stage valid; combinational OR of registers.

## Operation
- **Slot write.** At a clk edge with `in_wr_en[i]` and `in_full[i]==0`, slot i captures `in_din[i]` and `in_full[i]` is set to 1. A write while `in_full[i]==1` is ignored, with no side effect.
- **Output accept.** At an edge with `out_wr_en==1` and `out_full==0`, `cdc_reg` takes the word and the output stage becomes free, unless it is reloaded on the same edge.
- **Output stage available** on an edge when `out_wr_en==0`, or when an output accept happens on that edge.
- **Grant.** When the output stage is available, the arbiter scans candidates `in_full & in_mask` starting at pointer `ptr` and ascending with wrap N-1→0. It grants the first hit g.
- **On a grant, on that edge:**
  - `out_dout` ← slot g.
  - `out_id` ← g.
  - `out_wr_en` ← 1.
  - `in_full[g]` ← 0.
  - `ptr` ← (g+1) mod N, with wrap at N-1→0.
- **No grant.**
  - If no candidate exists and an output accept occurred, `out_wr_en` ← 0.
  - `out_dout`/`out_id` hold their last value.
  - `ptr` holds.
- **Slot freed and written on the same edge.** The grant's clear of `in_full[g]` wins over any write. A requester whose `in_full[g]` was 1 during that cycle was not writing legally, so no data is lost. A write to slot g is accepted on the next cycle.
- **Mask changes.**
  - Masking an occupied slot keeps its data and keeps `in_full` at 1 indefinitely.
  - Unmasking makes it a candidate on the next arbitration.
  - The mask never affects slot writes.
- **One grant per cycle at most.**
- **Reset.** `rst` at an edge forces all of the following, discarding any slot or output-stage data mid-transfer:
  - `in_full`=0
  - `out_wr_en`=0
  - `out_dout`=0
  - `out_id`=0
  - `ptr`=0
  - `busy`=0 in the following cycle

## Timing
- All outputs are registered except `busy`.
- **Latency.** Write sampled at edge t (output stage free, slot i the only candidate):
  - `in_full[i]`=1 during t..t+1.
  - Grant at edge t+1.
  - `out_wr_en`=1 with data from t+1.
  - Earliest `cdc_reg` capture at edge t+2.
- **Throughput.**
  - With `out_full` held 0: one word per cycle.
  - With a real `cdc_reg`: `full` rises the cycle after capture, so `out_wr_en` stays asserted with the next word until `full` falls.
- **Stability.** `out_wr_en`, `out_dout` and `out_id` do not change while `out_wr_en==1` and `out_full==1`.
- **Fairness.** With all N requesters continuously occupied and unmasked, every requester receives a grant within N consecutive grants.

## Test plan
- **Reset values.**
  - Stimulus: assert `rst` mid-transfer with all slots full and `out_wr_en`=1.
  - Required: next cycle `in_full`=0, `out_wr_en`=0, `out_dout`=0, `out_id`=0, `busy`=0; first grant after release goes to requester 0.
- **Single path.**
  - Stimulus: N=4, `out_full`=0; requester 2 writes 0xA5 at edge t.
  - Required: `in_full[2]`=1 in cycle t; `out_wr_en`=1, `out_dout`=0xA5, `out_id`=2 from t+1; `in_full[2]`=0 from t+1.
- **Round-robin with wrap.**
  - Stimulus: all four slots loaded on the same edge with 0x10..0x13; `out_full`=0.
  - Required: `out_id` sequence 0,1,2,3 on consecutive cycles.
  - Stimulus: refill slots 0 and 3 on the same edge.
  - Required: `out_id` sequence 0,3 (ptr had wrapped to 0).
- **Backpressure.**
  - Stimulus: hold `out_full`=1 for 5 cycles while `out_wr_en`=1 with id 1.
  - Required: `out_dout`/`out_id` stable; other slots stay full; ignored writes to full slots leave slot data unchanged.
  - Stimulus: drop `out_full`.
  - Required: next pending id is presented the cycle after capture.
- **Mask.**
  - Stimulus: `in_mask`=4'b1011 with slots 2 and 3 full.
  - Required: only id 3 is granted; slot 2 keeps `in_full`=1 and `busy`=1.
  - Stimulus: set mask bit 2.
  - Required: id 2 is granted on the next available cycle.
- **Real `cdc_reg` hookup.**
  - Stimulus: connect a `cdc_reg` with `rd_clk` = 1.5× `clk`; send 1000 random words from 4 requesters under random `rd_en`.
  - Required: per-id order preserved; no word lost or duplicated.

Source files
------------

// File: rtl/cdc_reg_arbiter_if.sv
// rtl/cdc_reg_arbiter_if.sv - requester slots and cdc_reg write-side bundle for cdc_reg_arbiter
interface cdc_reg_arbiter_if #(
  parameter int N        = 4,
  parameter int WIDTH    = 128,
  parameter int ID_WIDTH = 2
) ();
  logic [N*WIDTH-1:0]  in_din;
  logic [N-1:0]        in_wr_en;
  logic [N-1:0]        in_full;
  logic [N-1:0]        in_mask;
  logic [WIDTH-1:0]    out_dout;
  logic [ID_WIDTH-1:0] out_id;
  logic                out_wr_en;
  logic                out_full;
  logic                busy;

  modport slave (
    input  in_din, in_wr_en, in_mask, out_full,
    output in_full, out_dout, out_id, out_wr_en, busy
  );

  modport master (
    output in_din, in_wr_en, in_mask, out_full,
    input  in_full, out_dout, out_id, out_wr_en, busy
  );
endinterface

// File: rtl/cdc_reg_arbiter.sv
// rtl/cdc_reg_arbiter.sv - round-robin arbiter sharing one cdc_reg write port among N requesters
// Single-entry slot per requester, one grant per cycle into a registered output stage.
module cdc_reg_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 128,
  parameter int ID_WIDTH = 2
) (
  input logic              clk,
  input logic              rst,
  cdc_reg_arbiter_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][WIDTH-1:0] slot_q;
  logic [N-1:0]            full_q, full_d, wr_ok, cand;
  logic [WIDTH-1:0]        dout_q, dout_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic                    vld_q, vld_d;
  logic [PW-1:0]           ptr_q, ptr_d, gnt_idx, scan_idx;
  logic [PW:0]             scan_sum;
  logic                    gnt_found, accept, avail;

  assign wr_ok  = bus.in_wr_en & ~full_q;
  assign cand   = full_q & bus.in_mask;
  assign accept = vld_q & ~bus.out_full;
  assign avail  = ~vld_q | accept;

  // First candidate at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(N)) scan_sum = scan_sum - (PW+1)'(N);
      scan_idx = scan_sum[PW-1:0];
      if (!gnt_found && cand[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    full_d = full_q | wr_ok;
    dout_d = dout_q;
    id_d   = id_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (avail && gnt_found) begin
      dout_d          = slot_q[gnt_idx];
      id_d            = ID_WIDTH'(gnt_idx);
      vld_d           = 1'b1;
      full_d[gnt_idx] = 1'b0;
      ptr_d           = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end else if (accept) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      dout_q <= '0;
      id_q   <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      dout_q <= dout_d;
      id_q   <= id_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  // Slot data needs no reset; its full flag is what qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (wr_ok[i]) slot_q[i] <= bus.in_din[i*WIDTH +: WIDTH];
    end
  end

  assign bus.in_full   = full_q;
  assign bus.out_dout  = dout_q;
  assign bus.out_id    = id_q;
  assign bus.out_wr_en = vld_q;
  assign bus.busy      = (|full_q) | vld_q;
endmodule

// File: tb/tb_cdc_reg_arbiter.sv
// tb/tb_cdc_reg_arbiter.sv - scoreboard testbench for cdc_reg_arbiter
module tb_cdc_reg_arbiter;
  localparam int N = 4;
  localparam int W = 128;
  localparam int IW = 2;

  typedef struct { logic [IW-1:0] id; logic [W-1:0] data; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mon_hit;
  int   seq = 0;
  exp_t exp_q[$];

  cdc_reg_arbiter_if #(.N(N), .WIDTH(W), .ID_WIDTH(IW)) bus ();

  cdc_reg_arbiter #(.N(N), .WIDTH(W), .ID_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int id, input logic [W-1:0] data, input bit expect_it);
    bus.in_wr_en[id] = 1'b1;
    bus.in_din[id*W +: W] = data;
    if (expect_it) exp_q.push_back('{id: IW'(id), data: data});
  endtask

  // Monitor: every word cdc_reg would capture must match the oldest expected word of its id.
  always @(negedge clk) begin
    if (!rst && bus.out_wr_en && !bus.out_full) begin
      mon_hit = -1;
      for (int k = 0; k < exp_q.size(); k++)
        if (mon_hit < 0 && exp_q[k].id == bus.out_id) mon_hit = k;
      if (mon_hit < 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual id=%0d data=%0h required=none", bus.out_id, bus.out_dout);
      end else begin
        check("word_data", bus.out_dout, exp_q[mon_hit].data);
        exp_q.delete(mon_hit);
      end
    end
  end

  initial begin
    bus.in_din   = '0;
    bus.in_wr_en = '0;
    bus.in_mask  = 4'hF;
    bus.out_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("init_in_full", bus.in_full, 0);
    check("init_out_wr_en", bus.out_wr_en, 0);

    // Single path: requester 2 writes 0xA5.
    put(2, 'hA5, 1);
    tick();
    bus.in_wr_en = '0;
    check("single_in_full_t", bus.in_full, 4'b0100);
    check("single_wr_en_t", bus.out_wr_en, 0);
    check("single_busy_t", bus.busy, 1);
    tick();
    check("single_wr_en", bus.out_wr_en, 1);
    check("single_dout", bus.out_dout, 'hA5);
    check("single_id", bus.out_id, 2);
    check("single_in_full", bus.in_full, 0);
    tick();
    check("single_idle_wr_en", bus.out_wr_en, 0);
    check("single_idle_busy", bus.busy, 0);

    // Reset mid-transfer with all slots full and output stalled.
    bus.out_full = 1'b1;
    for (int i = 0; i < N; i++) put(i, 'hF0 + i, 0);
    tick();
    bus.in_wr_en = '0;
    tick();
    check("pre_rst_wr_en", bus.out_wr_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_full = 1'b0;
    check("rst_in_full", bus.in_full, 0);
    check("rst_wr_en", bus.out_wr_en, 0);
    check("rst_dout", bus.out_dout, 0);
    check("rst_id", bus.out_id, 0);
    check("rst_busy", bus.busy, 0);

    // Round robin 0,1,2,3 then refill 0 and 3 after the pointer wrapped.
    for (int i = 0; i < N; i++) put(i, 'h10 + i, 1);
    tick();
    bus.in_wr_en = '0;
    check("rr_in_full", bus.in_full, 4'hF);
    for (int i = 0; i < N; i++) begin
      tick();
      check("rr_id", bus.out_id, i);
      check("rr_dout", bus.out_dout, 'h10 + i);
    end
    tick();
    check("rr_idle", bus.out_wr_en, 0);
    put(0, 'h20, 1);
    put(3, 'h23, 1);
    tick();
    bus.in_wr_en = '0;
    tick();
    check("wrap_id0", bus.out_id, 0);
    tick();
    check("wrap_id3", bus.out_id, 3);
    tick();
    check("wrap_idle", bus.out_wr_en, 0);

    // Backpressure: id 1 stalled five cycles, ignored write to full slot 2.
    bus.out_full = 1'b1;
    put(1, 'h31, 1);
    put(2, 'h32, 1);
    put(3, 'h33, 1);
    tick();
    bus.in_wr_en = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) put(2, 'hEE, 0);
      tick();
      bus.in_wr_en = '0;
      check("bp_wr_en", bus.out_wr_en, 1);
      check("bp_id", bus.out_id, 1);
      check("bp_dout", bus.out_dout, 'h31);
      check("bp_in_full", bus.in_full, 4'b1100);
    end
    bus.out_full = 1'b0;
    tick();
    check("bp_next_id", bus.out_id, 2);
    check("bp_next_dout", bus.out_dout, 'h32);
    tick();
    check("bp_last_id", bus.out_id, 3);
    check("bp_last_dout", bus.out_dout, 'h33);
    tick();
    check("bp_idle", bus.out_wr_en, 0);

    // Mask: slot 2 held while masked, granted once unmasked.
    bus.in_mask = 4'b1011;
    put(2, 'h42, 1);
    put(3, 'h43, 1);
    tick();
    bus.in_wr_en = '0;
    tick();
    check("mask_id3", bus.out_id, 3);
    check("mask_in_full", bus.in_full, 4'b0100);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("mask_held_wr_en", bus.out_wr_en, 0);
      check("mask_held_full", bus.in_full, 4'b0100);
      check("mask_held_busy", bus.busy, 1);
    end
    bus.in_mask = 4'hF;
    tick();
    check("unmask_id2", bus.out_id, 2);
    check("unmask_dout", bus.out_dout, 'h42);
    tick();
    check("unmask_busy", bus.busy, 0);

    // Random traffic with random backpressure; per-id order checked by the monitor.
    for (int c = 0; c < 1500; c++) begin
      bus.out_full = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        bus.in_wr_en[i] = 1'b0;
        if (!bus.in_full[i] && $urandom_range(0, 1) == 1) begin
          seq++;
          put(i, W'((i << 16) | seq), 1);
        end
      end
      tick();
    end
    bus.in_wr_en = '0;
    bus.out_full = 1'b0;
    for (int c = 0; c < 40 && bus.busy; c++) tick();
    check("drain_busy", bus.busy, 0);
    check("scoreboard_left", W'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
